hazard_scoreboard: RTL and testbench

- Parametrised successor to the per-stage RAW hazard/forwarding unit of the RV32I pipeline.
- Keeps a per-register count of in-flight writers, scanned across NSTG post-decode stages.
- For each of NRP read ports it resolves the source as one of: register file, forward from stage k, or stall.
- Extra behaviour:
  - variable-latency results (data-ready flag per stage);
  - flush of younger stages with scoreboard repair;
  - issue back-pressure on counter saturation;
  - saturating stall-cycle performance counter.

---
 rtl/hazard_scoreboard.sv | 132 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: per-register pending-writer counters plus per-port
// forwarding/stall resolution across NSTG post-decode writer stages.
module hazard_scoreboard #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned RAW    = 5,
  parameter int unsigned NRP    = 2,
  parameter int unsigned NSTG   = 3,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned NFLUSH = 1,
  localparam int unsigned SELW  = $clog2(NSTG + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_issue_valid,
  input  logic                 i_issue_regld,
  input  logic [RAW-1:0]       i_issue_rd,
  output logic                 o_issue_ready,
  input  logic [NRP-1:0]       i_rp_used,
  input  logic [NRP*RAW-1:0]   i_rp_addr,
  input  logic [NSTG-1:0]      i_stg_valid,
  input  logic [NSTG-1:0]      i_stg_regld,
  input  logic [NSTG*RAW-1:0]  i_stg_rd,
  input  logic [NSTG-1:0]      i_stg_rdy,
  input  logic [NSTG*XLEN-1:0] i_stg_data,
  input  logic                 i_wb_valid,
  input  logic [RAW-1:0]       i_wb_rd,
  input  logic                 i_flush,
  output logic [NRP*SELW-1:0]  o_fwd_sel,
  output logic [NRP*XLEN-1:0]  o_fwd_data,
  output logic                 o_hazard_stall_n,
  output logic [31:0]          o_stall_cycles
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt   [NREG];
  logic [CNT_W-1:0] w_cnt_d [NREG];
  logic [31:0]      r_stall_cycles;

  logic             w_issue_block;
  logic             w_issue_fire;
  logic [NSTG-1:0]  w_stg_wr;
  logic             w_underflow;
  int               w_net;
  logic [NRP-1:0]   w_port_stall;
  logic [RAW-1:0]   w_a;
  logic             w_hit;
  logic             w_wb_hit;
  logic             w_stall;

  assign w_stg_wr      = i_stg_valid & i_stg_regld;
  assign w_issue_block = i_issue_regld && (i_issue_rd != '0) && (r_cnt[i_issue_rd] == CntMax);
  assign w_issue_fire  = i_issue_valid && i_issue_regld && !w_issue_block;
  assign o_issue_ready = !w_issue_block;

  // Issue, writeback and flush kills are netted together so they can coincide freely.
  always_comb begin
    w_underflow = 1'b0;
    w_net       = 0;
    for (int r = 0; r < NREG; r++) begin
      w_net = int'(r_cnt[r]);
      if (w_issue_fire && i_issue_rd == RAW'(r)) w_net = w_net + 1;
      if (i_wb_valid && i_wb_rd == RAW'(r)) w_net = w_net - 1;
      for (int s = 0; s < NFLUSH; s++) begin
        if (i_flush && w_stg_wr[s] && i_stg_rd[s*RAW +: RAW] == RAW'(r)) w_net = w_net - 1;
      end
      if (r == 0) begin
        w_cnt_d[r] = '0;
      end else if (w_net < 0) begin
        w_cnt_d[r]  = '0;
        w_underflow = 1'b1;
      end else begin
        w_cnt_d[r] = CNT_W'(w_net);
      end
    end
  end

  always_comb begin
    o_fwd_sel    = '0;
    o_fwd_data   = '0;
    w_port_stall = '0;
    w_a          = '0;
    w_hit        = 1'b0;
    w_wb_hit     = 1'b0;
    for (int p = 0; p < NRP; p++) begin
      w_a   = i_rp_addr[p*RAW +: RAW];
      w_hit = 1'b0;
      if (i_rp_used[p] && w_a != '0) begin
        for (int s = 0; s < NSTG; s++) begin
          if (!w_hit && w_stg_wr[s] && i_stg_rd[s*RAW +: RAW] == w_a) begin
            w_hit = 1'b1;
            if (i_stg_rdy[s]) begin
              o_fwd_sel[p*SELW +: SELW]  = SELW'(s + 1);
              o_fwd_data[p*XLEN +: XLEN] = i_stg_data[s*XLEN +: XLEN];
            end else begin
              w_port_stall[p] = 1'b1;
            end
          end
        end
        // Last outstanding writer retiring now is visible through the write-first regfile.
        w_wb_hit = i_wb_valid && (i_wb_rd == w_a);
        if (!w_hit && r_cnt[w_a] != '0 && !(w_wb_hit && r_cnt[w_a] == CNT_W'(1))) begin
          w_port_stall[p] = 1'b1;
        end
      end
    end
    if (!i_rst_n) begin
      o_fwd_sel  = '0;
      o_fwd_data = '0;
    end
  end

  assign w_stall          = (|w_port_stall) || w_issue_block;
  assign o_hazard_stall_n = !i_rst_n || i_flush || !w_stall;
  assign o_stall_cycles   = r_stall_cycles;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt          <= '{default: '0};
      r_stall_cycles <= '0;
    end else begin
      r_cnt <= w_cnt_d;
      if (!o_hazard_stall_n && r_stall_cycles != 32'hFFFF_FFFF) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  underflow_a: assert property (@(posedge i_clk) disable iff (!i_rst_n) !w_underflow);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: vector table, directed corner sequences and a
// randomized run checked against a counting reference model.
module tb_hazard_scoreboard;
  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int RAW    = 5;
  localparam int NRP    = 2;
  localparam int NSTG   = 3;
  localparam int CNT_W  = 2;
  localparam int NFLUSH = 1;
  localparam int SELW   = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 issue_valid, issue_regld, issue_ready;
  logic [RAW-1:0]       issue_rd;
  logic [NRP-1:0]       rp_used;
  logic [NRP*RAW-1:0]   rp_addr;
  logic [NSTG-1:0]      stg_valid, stg_regld, stg_rdy;
  logic [NSTG*RAW-1:0]  stg_rd;
  logic [NSTG*XLEN-1:0] stg_data;
  logic                 wb_valid, flush, hazard_stall_n;
  logic [RAW-1:0]       wb_rd;
  logic [NRP*SELW-1:0]  fwd_sel;
  logic [NRP*XLEN-1:0]  fwd_data;
  logic [31:0]          stall_cycles;

  int          m_cnt[NREG];
  logic [31:0] m_stall;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .XLEN(XLEN), .NREG(NREG), .RAW(RAW), .NRP(NRP), .NSTG(NSTG), .CNT_W(CNT_W), .NFLUSH(NFLUSH)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_issue_valid(issue_valid), .i_issue_regld(issue_regld), .i_issue_rd(issue_rd),
    .o_issue_ready(issue_ready),
    .i_rp_used(rp_used), .i_rp_addr(rp_addr),
    .i_stg_valid(stg_valid), .i_stg_regld(stg_regld), .i_stg_rd(stg_rd),
    .i_stg_rdy(stg_rdy), .i_stg_data(stg_data),
    .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_flush(flush),
    .o_fwd_sel(fwd_sel), .o_fwd_data(fwd_data),
    .o_hazard_stall_n(hazard_stall_n), .o_stall_cycles(stall_cycles)
  );

  typedef struct {
    logic [2:0]  v, ld, rdy;
    logic [14:0] rd;
    logic [95:0] data;
    logic [1:0]  used;
    logic [9:0]  addr;
    logic [3:0]  esel;
    logic [63:0] edata;
    logic        estn;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: youngest matching stage decides; otherwise any unretired writer stalls.
  function automatic void ref_port(input int p, output int sel, output logic [31:0] data,
                                   output bit stall);
    logic [RAW-1:0] a;
    int pend;
    a = rp_addr[p*RAW +: RAW];
    sel = 0; data = '0; stall = 0;
    if (!rp_used[p] || a == 0) return;
    for (int s = 0; s < NSTG; s++) begin
      if (stg_valid[s] && stg_regld[s] && stg_rd[s*RAW +: RAW] == a) begin
        if (stg_rdy[s]) begin
          sel  = s + 1;
          data = stg_data[s*XLEN +: XLEN];
        end else begin
          stall = 1;
        end
        return;
      end
    end
    pend  = m_cnt[a] - ((wb_valid && wb_rd == a) ? 1 : 0);
    stall = (pend > 0);
  endfunction

  function automatic void compute_expect(output bit e_ready, output bit e_stall_n,
                                         output logic [3:0] e_sel, output logic [63:0] e_data);
    int sel;
    logic [31:0] d;
    bit st, any;
    e_sel = '0; e_data = '0; any = 0;
    e_ready = !(issue_regld && issue_rd != 0 && m_cnt[issue_rd] == CMAX);
    for (int p = 0; p < NRP; p++) begin
      ref_port(p, sel, d, st);
      e_sel[p*SELW +: SELW] = 2'(sel);
      e_data[p*XLEN +: XLEN] = d;
      any |= st;
    end
    e_stall_n = flush || !(any || !e_ready);
    if (!rst_n) begin
      e_ready = 1; e_stall_n = 1; e_sel = '0; e_data = '0;
    end
  endfunction

  function automatic int net_next(input int r, input bit e_ready);
    int n;
    n = m_cnt[r];
    if (issue_valid && e_ready && issue_regld && issue_rd == r) n++;
    if (wb_valid && wb_rd == r) n--;
    for (int s = 0; s < NFLUSH; s++)
      if (flush && stg_valid[s] && stg_regld[s] && stg_rd[s*RAW +: RAW] == r) n--;
    return n;
  endfunction

  function automatic bit any_underflow();
    bit er;
    er = !(issue_regld && issue_rd != 0 && m_cnt[issue_rd] == CMAX);
    for (int r = 1; r < NREG; r++) if (net_next(r, er) < 0) return 1;
    return 0;
  endfunction

  task automatic check_cycle(input string tag);
    bit er, esn;
    logic [3:0] es;
    logic [63:0] ed;
    #2;
    compute_expect(er, esn, es, ed);
    chk({tag, " issue_ready"}, 64'(issue_ready), 64'(er));
    chk({tag, " stall_n"}, 64'(hazard_stall_n), 64'(esn));
    chk({tag, " fwd_sel"}, 64'(fwd_sel), 64'(es));
    chk({tag, " fwd_data"}, fwd_data, ed);
    chk({tag, " stall_cycles"}, 64'(stall_cycles), rst_n ? 64'(m_stall) : 64'd0);
  endtask

  task automatic advance();
    bit er, esn;
    logic [3:0] es;
    logic [63:0] ed;
    int n;
    compute_expect(er, esn, es, ed);
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
      m_stall = '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        n = net_next(r, er);
        m_cnt[r] = (n < 0) ? 0 : n;
      end
      if (!esn && m_stall != 32'hFFFF_FFFF) m_stall++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid = 0; issue_regld = 0; issue_rd = '0;
    rp_used = '0; rp_addr = '0;
    stg_valid = '0; stg_regld = '0; stg_rdy = '0; stg_rd = '0; stg_data = '0;
    wb_valid = 0; wb_rd = '0; flush = 0;
  endtask

  task automatic do_issue(input logic [RAW-1:0] rd);
    clear_inputs();
    issue_valid = 1; issue_regld = 1; issue_rd = rd;
    check_cycle("issue");
    advance();
  endtask

  task automatic do_wb(input logic [RAW-1:0] rd);
    clear_inputs();
    wb_valid = 1; wb_rd = rd;
    check_cycle("wb");
    advance();
  endtask

  task automatic set_stage(input int s, input logic [RAW-1:0] rd, input logic rdy,
                           input logic [31:0] d);
    stg_valid[s] = 1; stg_regld[s] = 1; stg_rdy[s] = rdy;
    stg_rd[s*RAW +: RAW] = rd;
    stg_data[s*XLEN +: XLEN] = d;
  endtask

  initial begin
    logic [31:0] base;
    for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
    m_stall = '0;

    vecs[0] = '{3'b001, 3'b001, 3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'h1234}, 2'b01,
                {5'd0, 5'd3}, 4'b0001, {32'h0, 32'h1234}, 1'b1};
    vecs[1] = '{3'b011, 3'b011, 3'b011, {5'd0, 5'd7, 5'd7}, {32'h0, 32'hB, 32'hA}, 2'b11,
                {5'd7, 5'd7}, 4'b0101, {32'hA, 32'hA}, 1'b1};
    vecs[2] = '{3'b100, 3'b100, 3'b100, {5'd12, 5'd0, 5'd0}, {32'h55, 32'h0, 32'h0}, 2'b10,
                {5'd12, 5'd3}, 4'b1100, {32'h55, 32'h0}, 1'b1};
    vecs[3] = '{3'b010, 3'b010, 3'b000, {5'd0, 5'd9, 5'd0}, {32'h0, 32'hDEAD, 32'h0}, 2'b01,
                {5'd0, 5'd9}, 4'b0000, 64'h0, 1'b0};
    vecs[4] = '{3'b001, 3'b000, 3'b001, {5'd0, 5'd0, 5'd6}, {32'h0, 32'h0, 32'h66}, 2'b01,
                {5'd0, 5'd6}, 4'b0000, 64'h0, 1'b1};
    vecs[5] = '{3'b001, 3'b001, 3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h77}, 2'b11,
                {5'd0, 5'd0}, 4'b0000, 64'h0, 1'b1};
    vecs[6] = '{3'b010, 3'b010, 3'b000, {5'd0, 5'd9, 5'd0}, 96'h0, 2'b00,
                {5'd9, 5'd9}, 4'b0000, 64'h0, 1'b1};
    vecs[7] = '{3'b110, 3'b111, 3'b111, {5'd8, 5'd8, 5'd8}, {32'h2, 32'h1, 32'h0}, 2'b01,
                {5'd0, 5'd8}, 4'b0010, {32'h0, 32'h1}, 1'b1};
    vecs[8] = '{3'b011, 3'b011, 3'b010, {5'd0, 5'd10, 5'd10}, {32'h0, 32'h1, 32'h2}, 2'b01,
                {5'd0, 5'd10}, 4'b0000, 64'h0, 1'b0};
    vecs[9] = '{3'b011, 3'b011, 3'b001, {5'd0, 5'd4, 5'd3}, {32'h0, 32'h44, 32'h33}, 2'b11,
                {5'd4, 5'd3}, 4'b0001, {32'h0, 32'h33}, 1'b0};

    // Reset state
    clear_inputs();
    @(posedge clk);
    #1;
    check_cycle("reset");
    chk("reset stall_n", 64'(hazard_stall_n), 64'd1);
    chk("reset ready", 64'(issue_ready), 64'd1);
    chk("reset stall_cycles", 64'(stall_cycles), 64'd0);
    advance();
    rst_n = 1;
    advance();

    // Combinational resolution table with an empty scoreboard
    for (int i = 0; i < 10; i++) begin
      clear_inputs();
      stg_valid = vecs[i].v; stg_regld = vecs[i].ld; stg_rdy = vecs[i].rdy;
      stg_rd = vecs[i].rd; stg_data = vecs[i].data;
      rp_used = vecs[i].used; rp_addr = vecs[i].addr;
      check_cycle("vec");
      chk($sformatf("vec%0d fwd_sel", i), 64'(fwd_sel), 64'(vecs[i].esel));
      chk($sformatf("vec%0d fwd_data", i), fwd_data, vecs[i].edata);
      chk($sformatf("vec%0d stall_n", i), 64'(hazard_stall_n), 64'(vecs[i].estn));
      advance();
    end

    // EX forward after a real issue
    do_issue(5'd3);
    clear_inputs();
    set_stage(0, 5'd3, 1'b1, 32'h1234);
    rp_used = 2'b01; rp_addr = {5'd0, 5'd3};
    check_cycle("exfwd");
    chk("exfwd sel", 64'(fwd_sel), 64'h1);
    chk("exfwd data", 64'(fwd_data[31:0]), 64'h1234);
    chk("exfwd stall_n", 64'(hazard_stall_n), 64'd1);
    advance();
    do_wb(5'd3);

    // Load-use: three stall cycles then forward from stage 1
    do_issue(5'd9);
    base = m_stall;
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      set_stage(1, 5'd9, 1'b0, 32'h0);
      rp_used = 2'b01; rp_addr = {5'd0, 5'd9};
      check_cycle("loaduse wait");
      chk("loaduse stall", 64'(hazard_stall_n), 64'd0);
      advance();
    end
    clear_inputs();
    set_stage(1, 5'd9, 1'b1, 32'hDEAD);
    rp_used = 2'b01; rp_addr = {5'd0, 5'd9};
    check_cycle("loaduse go");
    chk("loaduse sel", 64'(fwd_sel), 64'h2);
    chk("loaduse data", 64'(fwd_data[31:0]), 64'hDEAD);
    chk("loaduse stall_n", 64'(hazard_stall_n), 64'd1);
    chk("loaduse stall_cycles", 64'(stall_cycles), 64'(base + 32'd3));
    advance();
    do_wb(5'd9);

    // Flush repair
    do_issue(5'd4);
    clear_inputs();
    set_stage(0, 5'd4, 1'b0, 32'h0);
    rp_used = 2'b01; rp_addr = {5'd0, 5'd4};
    flush = 1;
    check_cycle("flush");
    chk("flush override", 64'(hazard_stall_n), 64'd1);
    advance();
    clear_inputs();
    rp_used = 2'b01; rp_addr = {5'd0, 5'd4};
    check_cycle("post flush");
    chk("post flush stall_n", 64'(hazard_stall_n), 64'd1);
    chk("post flush sel", 64'(fwd_sel), 64'h0);
    advance();
    do_issue(5'd4);
    clear_inputs();
    set_stage(0, 5'd4, 1'b0, 32'h0);
    flush = 1; issue_valid = 1; issue_regld = 1; issue_rd = 5'd4;
    check_cycle("flush+issue");
    advance();
    clear_inputs();
    rp_used = 2'b01; rp_addr = {5'd0, 5'd4};
    check_cycle("flush+issue read");
    chk("flush+issue pending", 64'(hazard_stall_n), 64'd0);
    advance();
    clear_inputs();
    rp_used = 2'b01; rp_addr = {5'd0, 5'd4};
    wb_valid = 1; wb_rd = 5'd4;
    check_cycle("wb clears");
    chk("wb clears stall_n", 64'(hazard_stall_n), 64'd1);
    advance();

    // Counter saturation back-pressure
    for (int c = 0; c < 3; c++) do_issue(5'd2);
    clear_inputs();
    issue_valid = 1; issue_regld = 1; issue_rd = 5'd2;
    check_cycle("sat");
    chk("sat ready", 64'(issue_ready), 64'd0);
    chk("sat stall_n", 64'(hazard_stall_n), 64'd0);
    advance();
    wb_valid = 1; wb_rd = 5'd2;
    check_cycle("sat+wb");
    chk("sat+wb ready", 64'(issue_ready), 64'd0);
    advance();
    clear_inputs();
    issue_valid = 1; issue_regld = 1; issue_rd = 5'd2;
    check_cycle("sat accept");
    chk("sat accept ready", 64'(issue_ready), 64'd1);
    chk("sat accept stall_n", 64'(hazard_stall_n), 64'd1);
    advance();
    for (int c = 0; c < 3; c++) do_wb(5'd2);

    // Reset asserted mid-run with pending writers
    do_issue(5'd5);
    do_issue(5'd5);
    clear_inputs();
    set_stage(1, 5'd5, 1'b0, 32'h0);
    set_stage(0, 5'd6, 1'b1, 32'h66);
    rp_used = 2'b11; rp_addr = {5'd6, 5'd5};
    check_cycle("pre reset");
    chk("pre reset stall_n", 64'(hazard_stall_n), 64'd0);
    rst_n = 0;
    #1;
    chk("in reset stall_n", 64'(hazard_stall_n), 64'd1);
    chk("in reset sel", 64'(fwd_sel), 64'h0);
    chk("in reset data", fwd_data, 64'h0);
    check_cycle("in reset");
    advance();
    rst_n = 1;
    clear_inputs();
    rp_used = 2'b01; rp_addr = {5'd0, 5'd5};
    check_cycle("after reset");
    chk("after reset cnt5 clear", 64'(hazard_stall_n), 64'd1);
    chk("after reset stall_cycles", 64'(stall_cycles), 64'd0);
    advance();

    // Randomized run against the reference model
    for (int it = 0; it < 3000; it++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_regld = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 7));
      rp_used     = 2'($urandom);
      rp_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      stg_valid   = 3'($urandom);
      stg_regld   = 3'($urandom);
      stg_rdy     = 3'($urandom);
      stg_rd      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7))};
      stg_data    = {$urandom, $urandom, $urandom};
      wb_valid    = ($urandom_range(0, 2) != 0);
      wb_rd       = 5'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 9) == 0);
      if (any_underflow()) wb_valid = 0;
      if (any_underflow()) flush = 0;
      check_cycle("rand");
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
